// File: rtl/qpu_exu_trigger_timer.sv
// Experiment timebase and per-channel event capture for the QPU execute event/time queue.
// Optional QPU_TRIG_TIMESTAMP_EN adds chan_ts_o, holding time_o sampled at each channel load.
module qpu_exu_trigger_timer #(
   parameter  int TIME_W   = 16,
   parameter  int QI_NUM   = 2,
   parameter  int QI_W     = 8,
   parameter  int MEAS_NUM = 1,
   parameter  int MEAS_W   = 4,
   localparam int EVT_NUM  = QI_NUM + MEAS_NUM,
   localparam int EVT_DW   = QI_NUM*QI_W + MEAS_NUM*MEAS_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  stop_i,
   input  logic                  clk_ena_i,
   input  logic [EVT_NUM-1:0]    evt_vld_i,
   input  logic [EVT_DW-1:0]     evt_dat_i,
   input  logic [EVT_NUM-1:0]    chan_rdy_i,
   output logic                  trigger_o,
   output logic [TIME_W-1:0]     time_o,
   output logic [EVT_NUM-1:0]    chan_vld_o,
   output logic [EVT_DW-1:0]     chan_dat_o,
   output logic                  busy_o,
`ifdef QPU_TRIG_TIMESTAMP_EN
   output logic [EVT_NUM*TIME_W-1:0] chan_ts_o,
`endif
   output logic [EVT_NUM-1:0]    ovf_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

   state_t state_q, state_nxt;
   logic [EVT_NUM-1:0] load, drop;

   // State register; trigger is registered off the next state so it is high exactly in RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         trigger_o <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         trigger_o <= (state_nxt == RUN);
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (start_i) state_nxt = ARM;
         ARM:     state_nxt = RUN;
         RUN:     if (stop_i) state_nxt = DRAIN;
         DRAIN:   if (chan_vld_o == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state_q != IDLE);
   end

   // A held event may be replaced in the same cycle its consumer takes it.
   always_comb begin
      load = '0;
      drop = '0;
      for (int k = 0; k < EVT_NUM; k++) begin
         load[k] = (state_q == RUN) & evt_vld_i[k] & (~chan_vld_o[k] | chan_rdy_i[k]);
         drop[k] = (state_q == RUN) & evt_vld_i[k] & chan_vld_o[k] & ~chan_rdy_i[k];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         time_o <= '0;
         ovf_o  <= '0;
      end else if (state_q == ARM) begin
         time_o <= '0;
         ovf_o  <= '0;
      end else begin
         if ((state_q == RUN) && clk_ena_i)
            time_o <= time_o + 1'b1;
         ovf_o <= ovf_o | drop;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chan_vld_o <= '0;
      end else begin
         for (int k = 0; k < EVT_NUM; k++) begin
            if (load[k])
               chan_vld_o[k] <= 1'b1;
            else if (chan_rdy_i[k])
               chan_vld_o[k] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chan_dat_o <= '0;
      end else begin
         for (int k = 0; k < QI_NUM; k++)
            if (load[k])
               chan_dat_o[k*QI_W +: QI_W] <= evt_dat_i[k*QI_W +: QI_W];
         for (int m = 0; m < MEAS_NUM; m++)
            if (load[QI_NUM+m])
               chan_dat_o[QI_NUM*QI_W + m*MEAS_W +: MEAS_W] <=
                  evt_dat_i[QI_NUM*QI_W + m*MEAS_W +: MEAS_W];
      end
   end

`ifdef QPU_TRIG_TIMESTAMP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chan_ts_o <= '0;
      end else begin
         for (int k = 0; k < EVT_NUM; k++)
            if (load[k])
               chan_ts_o[k*TIME_W +: TIME_W] <= time_o;
      end
   end
`endif

endmodule

// File: tb/tb_qpu_exu_trigger_timer.sv
// Scoreboard bench for qpu_exu_trigger_timer: a cycle-level reference model queues expected
// channel data at capture time; a negedge monitor compares whatever the DUT presents.
module tb_qpu_exu_trigger_timer;
   localparam int EVT_NUM = 3;
   localparam int EVT_DW  = 20;

   logic clk = 1'b0;
   logic rst;
   logic start_i, stop_i, clk_ena_i;
   logic [EVT_NUM-1:0] evt_vld_i, chan_rdy_i;
   logic [EVT_DW-1:0]  evt_dat_i;
   logic               trigger_o, busy_o;
   logic [15:0]        time_o;
   logic [EVT_NUM-1:0] chan_vld_o, ovf_o;
   logic [EVT_DW-1:0]  chan_dat_o;
`ifdef QPU_TRIG_TIMESTAMP_EN
   logic [EVT_NUM*16-1:0] chan_ts_o;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model: phase 0=idle 1=arm 2=run 3=drain
   int m_phase;
   int m_time;
   bit m_hold [EVT_NUM];
   bit m_ovf  [EVT_NUM];
   int q_dat  [EVT_NUM][$];
   int q_ts   [EVT_NUM][$];

   qpu_exu_trigger_timer dut (
      .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .clk_ena_i(clk_ena_i),
      .evt_vld_i(evt_vld_i), .evt_dat_i(evt_dat_i), .chan_rdy_i(chan_rdy_i),
      .trigger_o(trigger_o), .time_o(time_o), .chan_vld_o(chan_vld_o),
      .chan_dat_o(chan_dat_o), .busy_o(busy_o),
`ifdef QPU_TRIG_TIMESTAMP_EN
      .chan_ts_o(chan_ts_o),
`endif
      .ovf_o(ovf_o)
   );

   always #5 clk = ~clk;

   function automatic int field(input logic [EVT_DW-1:0] bus, input int k);
      case (k)
         0:       return int'(bus[7:0]);
         1:       return int'(bus[15:8]);
         default: return int'(bus[19:16]);
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_phase = 0;
      m_time  = 0;
      for (int k = 0; k < EVT_NUM; k++) begin
         m_hold[k] = 1'b0;
         m_ovf[k]  = 1'b0;
         q_dat[k].delete();
         q_ts[k].delete();
      end
   endtask

   // Drive one cycle of stimulus (called at posedge+1), predict the effect of the next edge.
   task automatic cycle(input bit st, input bit sp, input bit en, input logic [2:0] v,
                        input logic [EVT_DW-1:0] d, input logic [2:0] r);
      int nphase, ntime;
      bit nhold [EVT_NUM];
      bit novf  [EVT_NUM];
      start_i = st; stop_i = sp; clk_ena_i = en;
      evt_vld_i = v; evt_dat_i = d; chan_rdy_i = r;
      nphase = m_phase; ntime = m_time; nhold = m_hold; novf = m_ovf;
      case (m_phase)
         0: if (st) nphase = 1;
         1: begin
            nphase = 2;
            ntime  = 0;
            for (int k = 0; k < EVT_NUM; k++) novf[k] = 1'b0;
         end
         2: begin
            if (en) ntime = (m_time + 1) % 65536;
            if (sp) nphase = 3;
         end
         default: if (!(m_hold[0] | m_hold[1] | m_hold[2])) nphase = 0;
      endcase
      for (int k = 0; k < EVT_NUM; k++) begin
         if (m_phase == 2 && v[k]) begin
            if (!m_hold[k] || r[k]) begin
               nhold[k] = 1'b1;
               q_dat[k].push_back(field(d, k));
               q_ts[k].push_back(m_time);
            end else begin
               novf[k] = 1'b1;
            end
         end else if (m_hold[k] && r[k]) begin
            nhold[k] = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      m_phase = nphase; m_time = ntime; m_hold = nhold; m_ovf = novf;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start_i = 0; stop_i = 0; clk_ena_i = 0; evt_vld_i = '0; evt_dat_i = '0; chan_rdy_i = '0;
      model_clear();
      #1;
      chk("rst_trigger", trigger_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_time", time_o, 0);
      chk("rst_vld", chan_vld_o, 0);
      chk("rst_dat", chan_dat_o, 0);
      chk("rst_ovf", ovf_o, 0);
`ifdef QPU_TRIG_TIMESTAMP_EN
      chk("rst_ts", chan_ts_o, 0);
`endif
      @(posedge clk); @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      chk("trigger", trigger_o, m_phase == 2);
      chk("busy", busy_o, m_phase != 0);
      chk("time", time_o, m_time);
      for (int k = 0; k < EVT_NUM; k++) begin
         chk($sformatf("vld%0d", k), chan_vld_o[k], m_hold[k]);
         chk($sformatf("ovf%0d", k), ovf_o[k], m_ovf[k]);
         if (chan_vld_o[k] === 1'b1) begin
            if (q_dat[k].size() == 0) begin
               chk($sformatf("sb_empty%0d", k), q_dat[k].size(), 1);
            end else begin
               chk($sformatf("dat%0d", k), field(chan_dat_o, k), q_dat[k][0]);
`ifdef QPU_TRIG_TIMESTAMP_EN
               chk($sformatf("ts%0d", k), chan_ts_o[k*16 +: 16], q_ts[k][0]);
`endif
               if (chan_rdy_i[k] === 1'b1) begin
                  void'(q_dat[k].pop_front());
                  void'(q_ts[k].pop_front());
               end
            end
         end
      end
   end

   initial begin
      int n;
      do_reset();
      chk("rst_dat_idle", chan_dat_o, 0);

      // start at cycle 0, ARM at cycle 1, RUN from cycle 2
      cycle(1, 0, 0, 3'b000, '0, 3'b000);
      chk("busy_c1", busy_o, 1);
      chk("trig_c1", trigger_o, 0);
      cycle(0, 0, 1, 3'b000, '0, 3'b000);
      chk("trig_c2", trigger_o, 1);
      chk("time_c2", time_o, 0);
      repeat (5) cycle(0, 0, 1, 3'b000, '0, 3'b000);
      chk("time_5", time_o, 5);
      repeat (3) cycle(0, 0, 0, 3'b000, '0, 3'b000);
      chk("time_stall", time_o, 5);

      // capture, hold, overflow, drain
      cycle(0, 0, 0, 3'b001, 20'h0005A, 3'b000);
      chk("cap_vld", chan_vld_o[0], 1);
      chk("cap_dat", chan_dat_o[7:0], 8'h5A);
      repeat (3) cycle(0, 0, 0, 3'b000, '0, 3'b000);
      cycle(0, 0, 0, 3'b001, 20'h00033, 3'b000);
      chk("ovf_keep", chan_dat_o[7:0], 8'h5A);
      chk("ovf_set", ovf_o[0], 1);
      cycle(0, 0, 0, 3'b000, '0, 3'b001);
      chk("drain0", chan_vld_o[0], 0);

      // back-to-back on the measurement channel
      cycle(0, 0, 1, 3'b100, 20'h30000, 3'b100);
      chk("b2b_a", chan_dat_o[19:16], 4'h3);
      cycle(0, 0, 1, 3'b100, 20'h90000, 3'b100);
      chk("b2b_b", chan_dat_o[19:16], 4'h9);
      chk("b2b_vld", chan_vld_o[2], 1);
      chk("b2b_ovf", ovf_o[2], 0);
      cycle(0, 0, 0, 3'b000, '0, 3'b100);

      // wrap: run the counter up to 0xFFFE, then two more advances
      n = (65534 - m_time + 65536) % 65536;
      for (int i = 0; i < n; i++) cycle(0, 0, 1, 3'b000, '0, 3'b000);
      chk("time_fffe", time_o, 16'hFFFE);
      cycle(0, 0, 1, 3'b000, '0, 3'b000);
      chk("time_ffff", time_o, 16'hFFFF);
      cycle(0, 0, 1, 3'b000, '0, 3'b000);
      chk("time_wrap", time_o, 16'h0000);

      // randomized traffic including stops and restarts
      for (int i = 0; i < 1500; i++)
         cycle((m_phase == 0) && ($urandom % 8 == 0), (m_phase == 2) && ($urandom % 64 == 0),
               1'($urandom), 3'($urandom), 20'($urandom), 3'($urandom));

      for (int i = 0; i < 50 && m_phase != 2; i++)
         cycle(m_phase == 0, 0, 1, 3'b000, '0, 3'b111);
      chk("reach_run", m_phase, 2);
      cycle(0, 0, 1, 3'b000, '0, 3'b111);

      // stop while channel 1 holds data, plus a drop on the stop cycle
      cycle(0, 0, 1, 3'b010, 20'h0AB00, 3'b000);
      cycle(0, 1, 1, 3'b010, 20'h0CD00, 3'b000);
      chk("stop_ovf1", ovf_o[1], 1);
      chk("stop_keep", chan_dat_o[15:8], 8'hAB);
      repeat (4) cycle(0, 0, 1, 3'b000, '0, 3'b000);
      chk("drain_trig", trigger_o, 0);
      chk("drain_busy", busy_o, 1);
      chk("drain_time_hold", time_o, m_time);
      cycle(0, 0, 0, 3'b000, '0, 3'b010);
      chk("drain_busy2", busy_o, 1);
      cycle(0, 0, 0, 3'b000, '0, 3'b000);
      chk("idle_busy", busy_o, 0);

      // start and stop together in IDLE: start wins; ARM clears ovf
      cycle(1, 1, 0, 3'b000, '0, 3'b000);
      cycle(0, 0, 0, 3'b000, '0, 3'b000);
      chk("arm_ovf_clr", ovf_o, 0);
      chk("restart_trig", trigger_o, 1);
      repeat (7) cycle(0, 0, 1, 3'b011, 20'($urandom), 3'b000);
      cycle(0, 0, 1, 3'b100, 20'h50000, 3'b000);

      // asynchronous reset mid-run
      do_reset();
      repeat (2) cycle(0, 0, 0, 3'b000, '0, 3'b000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
